// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Used by fetch_stage and fetch_hold_buffer.
package fetch_stage_pkg;

  typedef logic [31:0] instr_t;
  typedef logic [31:0] data_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DISCARD
  } fetch_state_t;

  localparam data_t  RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam instr_t NOP_INSTR_DEFAULT = 32'h0000_0013;

  function automatic data_t word_align(input data_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry holding register for a fetched word that arrives while decode is stalled.
// Clear wins over write, write wins over read.
module fetch_hold_buffer
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   write,
  input  logic   read,
  input  logic   clear,
  input  instr_t wdata,
  output logic   valid,
  output instr_t data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (write) begin
      valid <= 1'b1;
      data  <= wdata;
    end else if (read) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time and feeds decode.
// Optional macro FETCH_MISALIGN_TRAP_EN adds the fetch_misaligned output and parking on misaligned redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter data_t  RESET_PC  = RESET_PC_DEFAULT,
  parameter instr_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc_cur,
  output logic [31:0] if_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

  fetch_state_t state, state_next;
  data_t        pc, pc_next, pc_plus4;
  logic         load;
  instr_t       load_data;
  logic         hold_write, hold_read, hold_clear;
  logic         hold_valid;
  instr_t       hold_data;
  logic         park;
  fetch_state_t resume;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic         misaligned_next;
`endif

  assign pc_plus4       = pc + 32'd4;
  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc;

  fetch_hold_buffer u_hold (
    .clk   (clk),
    .reset (reset),
    .write (hold_write),
    .read  (hold_read),
    .clear (hold_clear),
    .wdata (imem_rsp_data),
    .valid (hold_valid),
    .data  (hold_data)
  );

  // Redirect outranks everything; a request already accepted leaves one response to drain in DISCARD.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load       = 1'b0;
    load_data  = imem_rsp_data;
    hold_write = 1'b0;
    hold_read  = 1'b0;
    hold_clear = 1'b0;
    resume     = REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_next = fetch_misaligned;
    park            = fetch_misaligned;
`else
    park            = 1'b0;
`endif

    if (redirect_valid) begin
      pc_next    = word_align(redirect_target);
      hold_clear = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_next = (redirect_target[1:0] != 2'b00);
      park            = misaligned_next;
`endif
      resume = park ? IDLE : REQ;
      case (state)
        WAIT:    state_next = imem_rsp_valid ? resume : DISCARD;
        REQ:     state_next = imem_req_ready ? DISCARD : resume;
        DISCARD: state_next = imem_rsp_valid ? resume : DISCARD;
        default: state_next = resume;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (!park) state_next = REQ;
        end
        REQ: begin
          if (imem_req_ready) state_next = WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (!if_valid || !id_stall) begin
              load       = 1'b1;
              pc_next    = pc_plus4;
              state_next = REQ;
            end else begin
              hold_write = 1'b1;
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          if (!id_stall && hold_valid) begin
            load       = 1'b1;
            load_data  = hold_data;
            hold_read  = 1'b1;
            pc_next    = pc_plus4;
            state_next = REQ;
          end
        end
        DISCARD: begin
          if (imem_rsp_valid) state_next = park ? IDLE : REQ;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // The IF/ID slot empties to a NOP when consumed without a replacement word.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid       <= 1'b0;
      if_instruction <= NOP_INSTR;
      if_pc_cur      <= '0;
      if_pc_plus4    <= '0;
    end else if (redirect_valid) begin
      if_valid       <= 1'b0;
      if_instruction <= NOP_INSTR;
    end else if (load) begin
      if_valid       <= 1'b1;
      if_instruction <= load_data;
      if_pc_cur      <= pc;
      if_pc_plus4    <= pc_plus4;
    end else if (if_valid && !id_stall) begin
      if_valid       <= 1'b0;
      if_instruction <= NOP_INSTR;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_misaligned <= 1'b0;
    end else begin
      fetch_misaligned <= misaligned_next;
    end
  end
`endif

endmodule
